// File: rtl/vga_mode_ctrl.sv
// vga_mode_ctrl: configuration sequencer for the VGA demo video path.
// Debounces the board switches and two push-buttons and drives the datapath
// select and background-colour controls. Manual mode follows the switches;
// auto-demo mode steps through the four path configurations every
// FRAMES_PER_STEP frames. Datapath controls change only on a frame tick.
//
// Ports:
//   i_clk          pixel/system clock
//   i_reset        asynchronous, active-high reset
//   i_sw[3:0]      raw switches: [1:0] background colour, [2] bypass bar, [3] bypass gray
//   i_btn_mode     raw button, toggles manual / auto
//   i_btn_pause    raw button, pauses / resumes auto stepping
//   i_vsync        vsync from the sync unit, synchronous to i_clk
//   o_bypass_bar   1 = background colour feeds the gray mux, 0 = bar pattern
//   o_bypass_gray  1 = colour passes through, 0 = gray conversion
//   o_back_rgb     background colour
//   o_state        0 = MANUAL, 1 = AUTO_RUN, 2 = AUTO_PAUSE
//   o_step         current auto step
//   o_frame_tick   one-cycle pulse at each frame boundary
module vga_mode_ctrl #(
    parameter int unsigned     CD              = 12,
    parameter int unsigned     DB_CYCLES       = 250000,
    parameter int unsigned     FRAMES_PER_STEP = 120,
    parameter logic [CD-1:0]   AUTO_BG         = 'h00F,
    parameter logic            VSYNC_ACTIVE    = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [3:0]    i_sw,
    input  logic          i_btn_mode,
    input  logic          i_btn_pause,
    input  logic          i_vsync,
    output logic          o_bypass_bar,
    output logic          o_bypass_gray,
    output logic [CD-1:0] o_back_rgb,
    output logic [1:0]    o_state,
    output logic [1:0]    o_step,
    output logic          o_frame_tick
);

    localparam int unsigned    DBW     = $clog2(DB_CYCLES);
    localparam int unsigned    FCW     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        StManual    = 2'd0,
        StAutoRun   = 2'd1,
        StAutoPause = 2'd2
    } state_t;

    // Debounce: bits [3:0] switches, [4] mode button, [5] pause button.
    logic [5:0]     w_raw;
    logic [5:0]     r_db;
    logic [DBW-1:0] r_db_cnt [6];

    assign w_raw = {i_btn_pause, i_btn_mode, i_sw};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_db <= '0;
            for (int i = 0; i < 6; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (w_raw[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= w_raw[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // Button press pulses on the rising edge of the debounced level.
    logic [1:0] r_btn_prev;
    logic       w_press_mode;
    logic       w_press_pause;

    assign w_press_mode  = r_db[4] & ~r_btn_prev[0];
    assign w_press_pause = r_db[5] & ~r_btn_prev[1];

    // Frame tick: registered leading-edge detect of vsync.
    logic r_vsync_prev;
    logic r_frame_tick;
    logic w_vs_edge;

    assign w_vs_edge = (i_vsync == VSYNC_ACTIVE) && (r_vsync_prev != VSYNC_ACTIVE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_btn_prev   <= '0;
            r_vsync_prev <= ~VSYNC_ACTIVE;
            r_frame_tick <= 1'b0;
        end else begin
            r_btn_prev   <= r_db[5:4];
            r_vsync_prev <= i_vsync;
            r_frame_tick <= w_vs_edge;
        end
    end

    // Mode FSM and auto-step counters.
    state_t         r_state, w_state_d;
    logic [1:0]     r_step, w_step_d;
    logic [FCW-1:0] r_fcnt, w_fcnt_d;

    always_comb begin
        w_state_d = r_state;
        w_step_d  = r_step;
        w_fcnt_d  = r_fcnt;

        if (r_state == StAutoRun && r_frame_tick) begin
            if (r_fcnt == FC_LAST) begin
                w_fcnt_d = '0;
                w_step_d = r_step + 2'd1;
            end else begin
                w_fcnt_d = r_fcnt + FCW'(1);
            end
        end

        // Mode press has priority over pause press in the same cycle.
        case (r_state)
            StManual: begin
                if (w_press_mode) begin
                    w_state_d = StAutoRun;
                    w_step_d  = 2'd0;
                    w_fcnt_d  = '0;
                end
            end
            StAutoRun: begin
                if (w_press_mode)       w_state_d = StManual;
                else if (w_press_pause) w_state_d = StAutoPause;
            end
            StAutoPause: begin
                if (w_press_mode)       w_state_d = StManual;
                else if (w_press_pause) w_state_d = StAutoRun;
            end
            default: w_state_d = StManual;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StManual;
            r_step  <= 2'd0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_d;
            r_step  <= w_step_d;
            r_fcnt  <= w_fcnt_d;
        end
    end

    // Pending configuration from the current (pre-update) state and step.
    logic          w_cfg_bb;
    logic          w_cfg_bg;
    logic [CD-1:0] w_cfg_rgb;

    always_comb begin
        w_cfg_bb  = 1'b0;
        w_cfg_bg  = 1'b1;
        w_cfg_rgb = AUTO_BG;
        if (r_state == StManual) begin
            w_cfg_bb  = r_db[2];
            w_cfg_bg  = r_db[3];
            w_cfg_rgb = {{(CD-2){1'b0}}, r_db[1:0]};
        end else begin
            case (r_step)
                2'd0:    begin w_cfg_bb = 1'b0; w_cfg_bg = 1'b1; end
                2'd1:    begin w_cfg_bb = 1'b0; w_cfg_bg = 1'b0; end
                2'd2:    begin w_cfg_bb = 1'b1; w_cfg_bg = 1'b1; end
                default: begin w_cfg_bb = 1'b1; w_cfg_bg = 1'b0; end
            endcase
        end
    end

    // Datapath controls change only at a frame boundary to avoid tearing.
    logic          r_bb;
    logic          r_bg;
    logic [CD-1:0] r_rgb;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bb  <= 1'b0;
            r_bg  <= 1'b1;
            r_rgb <= '0;
        end else if (r_frame_tick) begin
            r_bb  <= w_cfg_bb;
            r_bg  <= w_cfg_bg;
            r_rgb <= w_cfg_rgb;
        end
    end

    assign o_bypass_bar  = r_bb;
    assign o_bypass_gray = r_bg;
    assign o_back_rgb    = r_rgb;
    assign o_state       = r_state;
    assign o_step        = r_step;
    assign o_frame_tick  = r_frame_tick;

endmodule

// File: doc/vga_mode_ctrl.md
Name: vga_mode_ctrl

Overview:
- Configuration sequencer for the VGA demo video path: bar generator, colour-to-gray converter and the two source-select muxes.
- Debounces the board switches and two push-buttons, then drives the datapath select and background-colour controls.
- Two modes: manual, where the switches drive the controls, and auto-demo, which steps through the four path configurations every N frames.
- All control changes are applied only at a vsync frame boundary, so there is no mid-frame tearing.

Parameters:
- CD, 12, colour depth; width of back_rgb.
- DB_CYCLES, 250000, clock cycles an input must stay stable before its debounced value updates; must be at least 2.
- FRAMES_PER_STEP, 120, frames per auto-demo step; must be at least 1.
- AUTO_BG, 12'h00F, background colour used in auto mode; CD bits.
- VSYNC_ACTIVE, 0, active level of the vsync input.

Ports:
- clk  input  1  pixel/system clock
- reset  input  1  asynchronous, active-high reset
- sw  input  4  raw switches; [1:0] background colour, [2] bypass bar, [3] bypass gray
- btn_mode  input  1  raw button; toggles between manual and auto
- btn_pause  input  1  raw button; pauses or resumes auto stepping
- vsync  input  1  vsync from the sync unit, synchronous to clk
- bypass_bar  output  1  1 = background colour feeds the gray mux, 0 = bar pattern
- bypass_gray  output  1  1 = colour passes through, 0 = gray conversion
- back_rgb  output  CD  background colour
- state  output  2  0 = MANUAL, 1 = AUTO_RUN, 2 = AUTO_PAUSE
- step  output  2  current auto step
- frame_tick  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (asynchronous, active-high):
  - outputs: bypass_bar=0, bypass_gray=1, back_rgb=0, state=MANUAL, step=0, frame_tick=0.
  - internal: debounced values=0, debounce counters=0, frame counter=0, previous-vsync register = inactive level.
- Debounce, applied independently to each of the 6 raw inputs:
  - counter clears whenever raw equals the stable value;
  - otherwise the counter increments; at DB_CYCLES-1 the stable value takes raw and the counter clears.
  - A glitch shorter than DB_CYCLES never propagates.
- Button events:
  - a press is a one-cycle pulse on the 0->1 edge of the debounced button;
  - release produces no event.
- Frame tick:
  - frame_tick=1 in the cycle after vsync changes from the inactive to the active level (registered edge detect);
  - no event on the trailing edge.
- State transitions:
  - MANUAL + mode press -> AUTO_RUN; step=0, frame counter=0.
  - AUTO_RUN or AUTO_PAUSE + mode press -> MANUAL.
  - AUTO_RUN + pause press -> AUTO_PAUSE.
  - AUTO_PAUSE + pause press -> AUTO_RUN; counter and step resume without reset.
  - MANUAL + pause press -> ignored.
  - Mode press and pause press in the same cycle: mode wins, pause is dropped.
- Stepping in AUTO_RUN:
  - each frame tick increments the frame counter;
  - at FRAMES_PER_STEP-1 the counter wraps to 0 and step increments mod 4 (3 -> 0);
  - AUTO_PAUSE freezes both.
  - A frame tick in the same cycle as the MANUAL->AUTO_RUN transition is not counted.
- Pending configuration, combinational from the registered state, step and debounced switches:
  - MANUAL: bypass_bar=sw_db[2], bypass_gray=sw_db[3], back_rgb={CD-2 zeros, sw_db[1:0]}.
  - Auto step 0: bar colour, (0,1).
  - Auto step 1: bar gray, (0,0).
  - Auto step 2: background colour, (1,1), back_rgb=AUTO_BG.
  - Auto step 3: background gray, (1,0), back_rgb=AUTO_BG.
  - Auto steps 0 and 1 hold back_rgb=AUTO_BG.
- Output update:
  - outputs load the pending configuration only in a frame_tick cycle and hold otherwise;
  - the pending value sampled is the pre-update one, so a state or step change takes effect on the following frame tick.
  - Manual switch changes therefore appear at the first frame tick after debounce.
- state and step outputs are live registers and are not frame-gated.
- Reset mid-operation returns to MANUAL with reset values immediately, independent of clk.

Test Plan:
- Reset and manual apply (DB_CYCLES=4, FRAMES_PER_STEP=2): assert reset with sw=4'b1011 held, release, then generate vsync active-low pulses. Required: outputs stay bypass_bar=0, bypass_gray=1, back_rgb=0 until the first frame tick; after it, bypass_bar=0, bypass_gray=1, back_rgb=12'h003.
- Debounce: a 3-cycle glitch on sw[2] produces no change at any frame tick. A 10-cycle hold on sw[2]=1 gives bypass_bar=1 after the next frame tick.
- Auto sequence: press btn_mode (held 10 cycles), then run 9 frames. Required: state=1 and step advances 0,0,1,1,2,2,3,3,0 per frame. Outputs lag by one tick: (0,1), (0,0), (1,1), (1,0); back_rgb=12'h00F throughout.
- Pause: press btn_pause at step=2. Required: state=2 and step holds 2 across 6 frames. Press again: state=1, counting resumes from the held counter value.
- Simultaneous presses: btn_mode and btn_pause debounced in the same cycle while in AUTO_RUN -> state=0, no pause. btn_pause alone in MANUAL -> state stays 0.
- Reset mid-auto at step=3 with vsync toggling: all outputs return to their reset values combinationally after reset assertion. After release, the first frame tick shows the manual switch configuration.
